// File: rtl/pipeline_skid_buffer.sv
// Two-entry elastic stage (main + skid register); 1-cycle latency, 1 word/cycle sustained.
// Backpressure: in_ready is decoded from the state flops only (low in FULL); optional flush via PIPELINE_SKID_FLUSH_EN.
module pipeline_skid_buffer #(
   parameter int          N           = 32,
   parameter logic [N-1:0] RESET_VALUE = '0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data
`ifdef PIPELINE_SKID_FLUSH_EN
   ,
   input  logic         flush
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   main_q, main_d;
   logic [N-1:0]   skid_q, skid_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         main_q  <= RESET_VALUE;
         skid_q  <= RESET_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_valid) begin
               main_d  = in_data;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (in_valid && out_ready) begin
               main_d = in_data;
            end else if (in_valid) begin
               skid_d  = in_data;
               state_d = FULL;
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // in_ready is low here, so in_valid is deliberately ignored
            if (out_ready) begin
               main_d  = skid_q;
               state_d = BUSY;
            end
         end
         default: state_d = EMPTY;
      endcase
`ifdef PIPELINE_SKID_FLUSH_EN
      if (flush) begin
         state_d = EMPTY;
         main_d  = RESET_VALUE;
         skid_d  = RESET_VALUE;
      end
`endif
   end

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;

endmodule
